// File: rtl/aes256_iter_ctrl.sv
// rtl/aes256_iter_ctrl.sv - iterative AES-256 encryption engine, one round per clock
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     block input handshake; key and data_in are sampled on accept
//   key[255:0]            cipher key
//   data_in[127:0]        plaintext
//   out_valid/out_ready   ciphertext output handshake
//   data_out[127:0]       ciphertext, held stable while out_valid is high
//   busy                  engine is not idle
//   round_idx[3:0]        round currently being computed (0 when idle/done)
module aes256_iter_ctrl #(
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [255:0] key,
    input  logic [127:0] data_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data_out,
    output logic         busy,
    output logic [3:0]   round_idx
);

    if (NR != 14) begin : g_bad_nr
        $error("aes256_iter_ctrl: NR must be 14");
    end

    typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // S-box computed as GF(2^8) inverse (x^254 = x^2 * x^4 * ... * x^128) followed
    // by the affine transform; inverse of 0 falls out as 0, giving sbox(0) = 63.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0]  t;
        logic [7:0]  inv;
        logic [15:0] d;
        t   = gf_mul(x, x);
        inv = t;
        for (int i = 0; i < 6; i++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        d = {inv, inv};
        return inv ^ d[14:7] ^ d[13:6] ^ d[12:5] ^ d[11:4] ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the block is bits [127-8i -: 8]; byte index = row + 4*column.
    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
            o[103 - 32*c -: 8] = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    fsm_t         fsm_q;
    logic [127:0] state_q;
    logic [255:0] k_q;
    logic [31:0]  rcon_q;
    logic [3:0]   round_q;
    logic [127:0] data_out_q;
    logic         in_ready_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [255:0] k_d;
    logic [127:0] state_d;
    logic [127:0] sr;
    logic [127:0] round_key;
    logic [31:0]  e0, e1, e2, e3, e4, e5, e6, e7;

    // Next eight key-schedule words from the current eight {w0..w7} held in k_q.
    always_comb begin
        e0  = k_q[255:224] ^ sub_word({k_q[23:0], k_q[31:24]}) ^ rcon_q;
        e1  = k_q[223:192] ^ e0;
        e2  = k_q[191:160] ^ e1;
        e3  = k_q[159:128] ^ e2;
        e4  = k_q[127:96]  ^ sub_word(e3);
        e5  = k_q[95:64]   ^ e4;
        e6  = k_q[63:32]   ^ e5;
        e7  = k_q[31:0]    ^ e6;
        k_d = {e0, e1, e2, e3, e4, e5, e6, e7};
    end

    // Odd rounds use the upper-half words already in k_q's low half; even rounds
    // consume a fresh expansion, which is also written back into k_q.
    always_comb begin
        sr        = shift_rows(sub_bytes(state_q));
        round_key = round_q[0] ? k_q[127:0] : k_d[255:128];
        state_d   = (round_q == 4'(NR)) ? (sr ^ round_key) : (mix_columns(sr) ^ round_key);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q       <= IDLE;
            state_q     <= '0;
            k_q         <= '0;
            rcon_q      <= 32'h01000000;
            round_q     <= '0;
            data_out_q  <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (fsm_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        state_q    <= data_in ^ key[255:128];
                        k_q        <= key;
                        rcon_q     <= 32'h01000000;
                        round_q    <= 4'd1;
                        fsm_q      <= ROUND;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                ROUND: begin
                    state_q <= state_d;
                    if (!round_q[0]) begin
                        k_q    <= k_d;
                        rcon_q <= rcon_q << 1;
                    end
                    if (round_q == 4'(NR)) begin
                        fsm_q       <= DONE;
                        round_q     <= '0;
                        data_out_q  <= state_d;
                        out_valid_q <= 1'b1;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        fsm_q       <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: fsm_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign data_out  = data_out_q;
    assign busy      = busy_q;
    assign round_idx = round_q;

endmodule

// File: tb/tb_aes256_iter_ctrl.sv
// tb/tb_aes256_iter_ctrl.sv - directed self-checking bench for aes256_iter_ctrl
module tb_aes256_iter_ctrl;

    localparam logic [255:0] K3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] P3 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] CZ = 128'hdc95c078a2408989ad48a21492842087;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] key;
    logic [127:0] data_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] data_out;
    logic         busy;
    logic [3:0]   round_idx;

    aes256_iter_ctrl #(.NR(14)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
        .data_out(data_out), .busy(busy), .round_idx(round_idx)
    );

    always #5 clk = ~clk;

    int           total = 0;
    int           passed = 0;
    int           failed = 0;
    int           cyc = 0;
    int           acc_n = 0;
    int           out_n = 0;
    int           acc_cyc [0:15];
    logic [127:0] outs    [0:15];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst_n && in_valid && in_ready && acc_n < 16) begin
            acc_cyc[acc_n] <= cyc;
            acc_n          <= acc_n + 1;
        end
        if (rst_n && out_valid && out_ready && out_n < 16) begin
            outs[out_n] <= data_out;
            out_n       <= out_n + 1;
        end
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    int   n;
    int   base_a;
    int   base_o;
    logic bad;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; key = '0; data_in = '0;
        step(); step();
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_round_idx", round_idx, 0);
        chk("rst_data_out", data_out, 0);
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", in_ready, 1);

        // FIPS-197 C.3, with round tracking and then backpressure
        key = K3; data_in = P3; in_valid = 1'b1;
        step();
        chk("c3_accept_busy", busy, 1);
        chk("c3_accept_round", round_idx, 1);
        chk("c3_accept_in_ready", in_ready, 0);
        in_valid = 1'b0; key = '1; data_in = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
        for (int k = 1; k <= 13; k++) begin
            step();
            chk($sformatf("c3_round_idx_%0d", k + 1), round_idx, k + 1);
        end
        chk("c3_not_valid_r14", out_valid, 0);
        step();
        chk("c3_out_valid_14", out_valid, 1);
        chk("c3_data", data_out, C3);
        chk("c3_done_round_idx", round_idx, 0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (out_valid !== 1'b1 || data_out !== C3 || in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
        end
        chk("bp_stable", bad, 0);
        chk("bp_no_transfer", out_n, 0);
        out_ready = 1'b1;
        step();
        chk("bp_out_valid_low", out_valid, 0);
        chk("bp_in_ready_high", in_ready, 1);
        chk("bp_busy_low", busy, 0);
        chk("bp_out_count", out_n, 1);
        chk("bp_out_data", outs[0], C3);
        out_ready = 1'b0;

        // zero key / zero plaintext
        key = '0; data_in = '0; in_valid = 1'b1;
        step();
        in_valid = 1'b0; key = K3; data_in = P3;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("zero_latency", n, 14);
        chk("zero_data", data_out, CZ);
        out_ready = 1'b1;
        step();
        chk("zero_out_count", out_n, 2);
        chk("zero_out_data", outs[1], CZ);
        out_ready = 1'b0;

        // back-to-back with in_valid and out_ready held high
        base_a = acc_n; base_o = out_n;
        key = K3; data_in = P3; in_valid = 1'b1; out_ready = 1'b1;
        bad = 1'b0; n = 0;
        while (out_n < base_o + 2 && n < 80) begin
            step(); n++;
            if (busy === 1'b1 && in_ready !== 1'b0) bad = 1'b1;
            if (acc_n == base_a + 1) begin
                key = '0; data_in = '0;
            end else if (acc_n >= base_a + 2) begin
                in_valid = 1'b0; key = '1; data_in = '1;
            end
        end
        chk("b2b_bound", n < 80, 1);
        chk("b2b_in_ready_busy", bad, 0);
        chk("b2b_accepts", acc_n - base_a, 2);
        chk("b2b_spacing", acc_cyc[base_a + 1] - acc_cyc[base_a], 16);
        chk("b2b_first", outs[base_o], C3);
        chk("b2b_second", outs[base_o + 1], CZ);
        in_valid = 1'b0;
        step();

        // reset in the middle of a run
        key = K3; data_in = P3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (round_idx !== 4'd7 && n < 20) begin step(); n++; end
        chk("mid_reach_r7", round_idx, 7);
        base_o = out_n;
        rst_n = 1'b0;
        step();
        chk("mid_busy", busy, 0);
        chk("mid_out_valid", out_valid, 0);
        chk("mid_data_out", data_out, 0);
        chk("mid_round_idx", round_idx, 0);
        rst_n = 1'b1;
        step();
        chk("mid_in_ready", in_ready, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("mid_latency", n, 14);
        chk("mid_data", data_out, C3);
        step();
        chk("mid_out_count", out_n - base_o, 1);
        chk("mid_out_data", outs[base_o], C3);

        // reset while holding a finished block
        out_ready = 1'b0; key = '0; data_in = '0; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin step(); n++; end
        chk("done_rst_data", data_out, CZ);
        base_o = out_n;
        rst_n = 1'b0; out_ready = 1'b1;
        step();
        chk("done_rst_out_valid", out_valid, 0);
        chk("done_rst_data_out", data_out, 0);
        rst_n = 1'b1; out_ready = 1'b0;
        step();
        chk("done_rst_no_transfer", out_n - base_o, 0);
        chk("done_rst_in_ready", in_ready, 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
